mul_issue_sched: RTL and testbench

Issue scheduler and result sequencer for the shared integer multiply functional unit. It sits between the multiply reservation-station entries and the single iterative multiplier. Each cycle it selects one ready entry, drives the FU operand/handshake inputs, and returns a one-hot grant that frees the entry. It then arbitrates the FU result onto the CDB, or silently drains it when a pipeline flush kills the in-flight operation.

---
 rtl/mul_issue_sched.sv | 159 +++++++++++++++
 tb/tb_mul_issue_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_sched.sv
// Issue scheduler and result sequencer for the shared iterative multiplier.
// Define MUL_OLDEST_FIRST_EN to pick the oldest ROB tag instead of round-robin.
module mul_issue_sched #(
    parameter int N_REQ = 4,
    parameter int ROB_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0][31:0]     req_A,
    input  logic [N_REQ-1:0][31:0]     req_B,
    input  logic [N_REQ-1:0][ROB_W-1:0] req_rob,
    input  logic [N_REQ-1:0]           req_mulh,
    output logic [N_REQ-1:0]           grant,
    input  logic [ROB_W-1:0]           rob_head,
    input  logic                       fu_ready,
    output logic                       fu_valid_in,
    output logic [31:0]                fu_A,
    output logic [31:0]                fu_B,
    output logic [ROB_W-1:0]           fu_rob,
    output logic                       fu_mulh,
    input  logic                       fu_valid_out,
    output logic                       fu_yumi,
    output logic                       cdb_req,
    input  logic                       cdb_gnt,
    input  logic                       flush,
    output logic                       busy
);
    // state    | meaning
    // IDLE     | no multiply in flight, may issue
    // ISSUED   | FU computing; result may retire in the cycle it appears
    // DONE     | result waiting for the CDB
    // DRAIN    | killed result being consumed without broadcast
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUED = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic             killed, killed_nxt;
    logic [IDX_W-1:0] win;
    logic             any_valid;
    logic             issue;

`ifdef MUL_OLDEST_FIRST_EN
    logic [ROB_W-1:0] best_age, age;

    // Strict less-than keeps the lower index on equal ages.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        best_age  = '0;
        age       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            age = req_rob[k] - rob_head;
            if (req_valid[k] && (!any_valid || age < best_age)) begin
                any_valid = 1'b1;
                best_age  = age;
                win       = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;
    logic             unused_rob_head;

    assign unused_rob_head = ^rob_head;

    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (!any_valid && req_valid[cand[IDX_W-1:0]]) begin
                any_valid = 1'b1;
                win       = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (issue)
            ptr <= (win == IDX_W'(N_REQ-1)) ? '0 : win + 1'b1;
    end
`endif

    assign issue       = (state == S_IDLE) && any_valid && fu_ready && !flush;
    assign grant       = issue ? (N_REQ'(1) << win) : '0;
    assign fu_valid_in = issue;
    assign fu_A        = req_A[win];
    assign fu_B        = req_B[win];
    assign fu_rob      = req_rob[win];
    assign fu_mulh     = req_mulh[win];
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_nxt  = state;
        killed_nxt = killed;
        cdb_req    = 1'b0;
        fu_yumi    = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nxt  = S_ISSUED;
                    killed_nxt = 1'b0;
                end
            end
            S_ISSUED: begin
                cdb_req = fu_valid_out & ~killed & ~flush;
                if (flush)
                    killed_nxt = 1'b1;
                // A killed result is consumed the cycle it appears, so the
                // next issue can follow immediately.
                if (fu_valid_out) begin
                    if (killed || flush) begin
                        fu_yumi   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (cdb_gnt) begin
                        fu_yumi   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cdb_req = fu_valid_out & ~flush;
                if (flush) begin
                    state_nxt = S_DRAIN;
                end else if (cdb_gnt) begin
                    fu_yumi   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                fu_yumi   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            killed <= 1'b0;
        end else begin
            state  <= state_nxt;
            killed <= killed_nxt;
        end
    end
endmodule

// File: tb/tb_mul_issue_sched.sv
// Self-checking bench for mul_issue_sched with a behavioural 65-cycle FU model.
// Build with MUL_OLDEST_FIRST_EN defined to exercise oldest-first selection.
module tb_mul_issue_sched;
    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_A, req_B;
    logic [3:0][3:0]  req_rob;
    logic [3:0]       req_mulh;
    logic [3:0]       grant;
    logic [3:0]       rob_head;
    logic             fu_ready, fu_valid_in;
    logic [31:0]      fu_A, fu_B;
    logic [3:0]       fu_rob;
    logic             fu_mulh, fu_valid_out, fu_yumi, cdb_req, cdb_gnt, flush, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit fu_run = 0;
    int fu_cnt = 0;

    mul_issue_sched #(.N_REQ(4), .ROB_W(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_A(req_A), .req_B(req_B),
        .req_rob(req_rob), .req_mulh(req_mulh), .grant(grant), .rob_head(rob_head),
        .fu_ready(fu_ready), .fu_valid_in(fu_valid_in), .fu_A(fu_A), .fu_B(fu_B),
        .fu_rob(fu_rob), .fu_mulh(fu_mulh), .fu_valid_out(fu_valid_out), .fu_yumi(fu_yumi),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] robs;
        logic [3:0]  head;
        logic [3:0]  exp_rr;
        logic [3:0]  exp_old;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // FU model: launch at T, fu_valid_out from T+65 until fu_yumi is sampled.
    task automatic tick();
        if (reset) fu_run = 0;
        else if (fu_run) begin
            if (fu_cnt == 0) begin
                if (fu_yumi) fu_run = 0;
            end else fu_cnt--;
        end else if (fu_valid_in) begin
            fu_run = 1;
            fu_cnt = 64;
        end
        @(posedge clk);
        #1;
        cyc++;
        fu_ready = !fu_run;
        fu_valid_out = fu_run && (fu_cnt == 0);
        #1;
    endtask

    task automatic flight_checks();
        chk("no_grant_in_flight", 32'(grant), 32'(0));
        chk("busy_in_flight", 32'(busy), 32'(1));
        chk("no_early_cdb_req", 32'(cdb_req), 32'(0));
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            flight_checks();
            tick();
        end
    endtask

    task automatic wait_fu_out(input int maxc);
        int n;
        n = 0;
        while (!fu_valid_out && n < maxc) begin
            flight_checks();
            tick();
            n++;
        end
        if (!fu_valid_out) begin
            checks++;
            failures++;
            $display("FAIL fu_valid_out_timeout cycle=%0d waited=%0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        req_valid = 0;
        flush = 0;
        cdb_gnt = 0;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    // Selection rule: round-robin from pointer p, or smallest (rob - head) mod 16.
    function automatic int pick(input logic [3:0] v, input int p, input logic [15:0] robs,
                                input logic [3:0] head);
        int best;
        int bage;
        int age;
        best = -1;
        bage = 99;
`ifdef MUL_OLDEST_FIRST_EN
        for (int k = 0; k < 4; k++) begin
            age = (int'(robs[4*k +: 4]) - int'(head) + 16) % 16;
            if (v[k] && age < bage) begin
                bage = age;
                best = k;
            end
        end
`else
        age = 0;
        for (int k = 0; k < 4; k++) begin
            if (best < 0 && v[(p + k) % 4]) best = (p + k) % 4;
        end
`endif
        return best;
    endfunction

    int w, mptr;
    logic [3:0] e;
    bit m_out, m_killed, m_seen, m_drain, e_iss, kill, e_cdb, e_yumi;

    initial begin
        vt[0] = '{4'b0100, 16'hE2F3, 4'd14, 4'b0100, 4'b0100};
        vt[1] = '{4'b1111, 16'hE1F3, 4'd14, 4'b1000, 4'b1000};
        vt[2] = '{4'b1111, 16'hE1F3, 4'd0,  4'b0001, 4'b0100};
        vt[3] = '{4'b0001, 16'hE1F3, 4'd0,  4'b0001, 4'b0001};
        vt[4] = '{4'b1010, 16'hE1F3, 4'd0,  4'b0010, 4'b1000};
        vt[5] = '{4'b0101, 16'hE1F3, 4'd2,  4'b0100, 4'b0001};
        vt[6] = '{4'b0011, 16'hE1F3, 4'd3,  4'b0001, 4'b0001};
        vt[7] = '{4'b0110, 16'h5555, 4'd0,  4'b0010, 4'b0010};

        fu_ready = 1; fu_valid_out = 0; req_A = '0; req_B = '0; req_rob = '0;
        req_mulh = 0; rob_head = 0; req_valid = 0; flush = 0; cdb_gnt = 0; reset = 1;
        do_reset();
        chk("reset_grant", 32'(grant), 32'(0));
        chk("reset_fu_valid_in", 32'(fu_valid_in), 32'(0));
        chk("reset_fu_yumi", 32'(fu_yumi), 32'(0));
        chk("reset_cdb_req", 32'(cdb_req), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));

        // Table: selection, operand mux and full single-op handshake per vector.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                req_A[k] = $urandom;
                req_B[k] = $urandom;
            end
            req_mulh = 4'($urandom);
            if (i == 0) begin
                req_A[2] = 32'd5;
                req_B[2] = 32'd7;
                req_mulh[2] = 1'b0;
            end
            req_valid = vt[i].valid;
            req_rob = vt[i].robs;
            rob_head = vt[i].head;
            #1;
`ifdef MUL_OLDEST_FIRST_EN
            e = vt[i].exp_old;
`else
            e = vt[i].exp_rr;
`endif
            w = 0;
            for (int k = 0; k < 4; k++) if (e[k]) w = k;
            chk("tbl_grant", 32'(grant), 32'(e));
            chk("tbl_fu_valid_in", 32'(fu_valid_in), 32'(1));
            chk("tbl_fu_A", fu_A, req_A[w]);
            chk("tbl_fu_B", fu_B, req_B[w]);
            chk("tbl_fu_rob", 32'(fu_rob), 32'(req_rob[w]));
            chk("tbl_fu_mulh", 32'(fu_mulh), 32'(req_mulh[w]));
            tick();
            wait_fu_out(80);
            cdb_gnt = 1;
            #1;
            chk("tbl_cdb_req", 32'(cdb_req), 32'(1));
            chk("tbl_fu_yumi", 32'(fu_yumi), 32'(1));
            tick();
            cdb_gnt = 0;
            req_valid = 0;
            #1;
            chk("tbl_busy_after", 32'(busy), 32'(0));
            chk("tbl_yumi_after", 32'(fu_yumi), 32'(0));
        end

`ifndef MUL_OLDEST_FIRST_EN
        // Round-robin fairness with all entries valid; also checks T+66 spacing.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            tick();
            wait_fu_out(80);
            cdb_gnt = 1;
            #1;
            chk("rr_yumi", 32'(fu_yumi), 32'(1));
            tick();
            cdb_gnt = 0;
        end
`endif

        // Back-pressure: cdb_gnt withheld 10 cycles.
        do_reset();
        req_valid = 4'b1111;
        req_rob = vt[1].robs;
        rob_head = 4'd14;
        #1;
        chk("bp_issue", 32'(fu_valid_in), 32'(1));
        tick();
        wait_fu_out(80);
        for (int k = 0; k < 10; k++) begin
            chk("bp_cdb_req_held", 32'(cdb_req), 32'(1));
            chk("bp_yumi_low", 32'(fu_yumi), 32'(0));
            chk("bp_no_grant", 32'(grant), 32'(0));
            tick();
        end
        cdb_gnt = 1;
        #1;
        chk("bp_cdb_req", 32'(cdb_req), 32'(1));
        chk("bp_yumi", 32'(fu_yumi), 32'(1));
        tick();
        cdb_gnt = 0;
        req_valid = 0;
        #1;
        chk("bp_busy_after", 32'(busy), 32'(0));

        // Flush in flight at T+30.
        do_reset();
        req_valid = 4'b0001;
        #1;
        chk("fl_grant", 32'(grant), 32'(1));
        tick();
        adv(29);
        flush = 1;
        #1;
        chk("fl_busy", 32'(busy), 32'(1));
        tick();
        flush = 0;
        #1;
        wait_fu_out(80);
        chk("fl_cdb_req", 32'(cdb_req), 32'(0));
        chk("fl_yumi", 32'(fu_yumi), 32'(1));
        tick();
        chk("fl_next_grant", 32'(grant), 32'(1));
        chk("fl_busy_after", 32'(busy), 32'(0));

        // Reset mid-operation: the op just launched above is abandoned.
        tick();
        adv(10);
        do_reset();
        req_valid = 4'b1111;
        req_rob = vt[1].robs;
        rob_head = 4'd14;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_grant", 32'(grant), 32'(4'b0001 << pick(4'b1111, 0, vt[1].robs, 4'd14)));

        // Flush in the issue cycle suppresses the grant.
        flush = 1;
        #1;
        chk("fi_grant", 32'(grant), 32'(0));
        chk("fi_fu_valid_in", 32'(fu_valid_in), 32'(0));
        tick();
        flush = 0;
        req_valid = 0;
        #1;
        chk("fi_busy", 32'(busy), 32'(0));

        // Flush coincident with cdb_gnt while waiting in DONE.
        do_reset();
        req_valid = 4'b0010;
        #1;
        chk("fd_grant", 32'(grant), 32'(4'b0010));
        tick();
        wait_fu_out(80);
        chk("fd_cdb_req_first", 32'(cdb_req), 32'(1));
        tick();
        flush = 1;
        cdb_gnt = 1;
        #1;
        chk("fd_cdb_req", 32'(cdb_req), 32'(0));
        chk("fd_yumi_flush", 32'(fu_yumi), 32'(0));
        tick();
        flush = 0;
        cdb_gnt = 0;
        #1;
        chk("fd_drain_yumi", 32'(fu_yumi), 32'(1));
        chk("fd_drain_busy", 32'(busy), 32'(1));
        chk("fd_drain_cdb_req", 32'(cdb_req), 32'(0));
        chk("fd_drain_grant", 32'(grant), 32'(0));
        tick();
        chk("fd_idle_busy", 32'(busy), 32'(0));
        chk("fd_idle_grant", 32'(grant), 32'(4'b0010));

        // Randomized run against a transaction-level model.
        do_reset();
        mptr = 0;
        m_out = 0; m_killed = 0; m_seen = 0; m_drain = 0;
        for (int c = 0; c < 3000; c++) begin
            req_valid = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                req_A[k] = $urandom;
                req_B[k] = $urandom;
                req_rob[k] = 4'($urandom);
            end
            req_mulh = 4'($urandom);
            rob_head = 4'($urandom);
            cdb_gnt = ($urandom % 3) != 0;
            flush = ($urandom % 150) == 0;
            #1;
            w = pick(req_valid, mptr, req_rob, rob_head);
            e_iss = !m_out && !m_drain && fu_ready && !flush && (req_valid != 0);
            kill = m_killed || flush;
            e_cdb = m_out && fu_valid_out && !kill;
            e_yumi = m_drain || (m_out && fu_valid_out &&
                                 ((!m_seen && kill) || (!kill && cdb_gnt)));
            chk("rnd_grant", 32'(grant), e_iss ? 32'(4'b0001 << w) : 32'(0));
            chk("rnd_fu_valid_in", 32'(fu_valid_in), 32'(e_iss));
            chk("rnd_cdb_req", 32'(cdb_req), 32'(e_cdb));
            chk("rnd_fu_yumi", 32'(fu_yumi), 32'(e_yumi));
            chk("rnd_busy", 32'(busy), 32'(m_out || m_drain));
            if (e_iss) begin
                chk("rnd_fu_A", fu_A, req_A[w]);
                chk("rnd_fu_rob", 32'(fu_rob), 32'(req_rob[w]));
                chk("rnd_fu_mulh", 32'(fu_mulh), 32'(req_mulh[w]));
            end
            if (e_yumi) begin
                m_out = 0;
                m_drain = 0;
            end else if (m_out && fu_valid_out && m_seen && flush) begin
                m_out = 0;
                m_drain = 1;
            end else if (m_out) begin
                if (flush) m_killed = 1;
                if (fu_valid_out) m_seen = 1;
            end
            if (e_iss) begin
                m_out = 1;
                m_killed = 0;
                m_seen = 0;
                mptr = (w + 1) % 4;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
